// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
//   Data-memory bus between the memory-access stage and a 32-bit data memory.
//
//   Handshake: the stage raises dmem_req with dmem_addr/dmem_we/dmem_wdata/
//   dmem_be stable and holds them until the memory answers with dmem_ready=1.
//   The beat completes on the rising edge where dmem_req=1 and dmem_ready=1;
//   for reads, dmem_rdata is valid only in that cycle. dmem_ready is ignored
//   while dmem_req=0.
//
//   Signals
//     dmem_req    stage -> mem  beat request
//     dmem_we     stage -> mem  1 = write beat
//     dmem_addr   stage -> mem  word address (low 2 bits are 0)
//     dmem_wdata  stage -> mem  write data
//     dmem_be     stage -> mem  byte enables, bit i covers wdata[8i+7:8i]
//     dmem_rdata  mem -> stage  read data
//     dmem_ready  mem -> stage  beat complete
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory-stage access unit between EX/MEM and MEM/WB (memWrRegister).
//   Runs byte/half/word loads and stores and two-beat FP double loads/stores
//   against a handshaked 32-bit data memory, formats load data, and drives the
//   pipeline stall, the MEM/WB write enable and the exception flag.
//
//   Ports
//     clk, rst_n                 clock (rising edge), async active-low reset
//     memRead, memWrite          load / store request from EX/MEM
//     memSize                    00 byte, 01 half, 10 word, 11 double
//     memSigned                  sign-extend byte/half loads
//     aluResultMem               effective byte address
//     storeData, fp_storeData    integer / FP double store data
//     dmem                       data-memory bus (master side)
//     memData, fp_busWMem        load results to memWrRegister
//     memStall                   freeze PC, IF/ID, ID/EX, EX/MEM
//     memWrEn                    memWrRegister write enable (= ~memStall)
//     memExc                     misaligned or timed-out access
//     dbg_state                  current FSM state (IDLE=0 BEAT0=1 BEAT1=2 DONE=3)
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic [1:0]           memSize,
    input  logic                 memSigned,
    input  logic [31:0]          aluResultMem,
    input  logic [31:0]          storeData,
    input  logic [63:0]          fp_storeData,
    mem_access_stage_if.master   dmem,
    output logic [31:0]          memData,
    output logic [63:0]          fp_busWMem,
    output logic                 memStall,
    output logic                 memWrEn,
    output logic                 memExc,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam bit               TMO_EN = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tflag_q, tflag_d;

    logic             op, mis, is_byte, is_half, is_word, is_dbl;
    logic [CNT_W-1:0] tcnt_inc;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_fmt;
    logic [31:0]      addr_w;

    assign op       = memRead | memWrite;
    assign is_byte  = (memSize == 2'b00);
    assign is_half  = (memSize == 2'b01);
    assign is_word  = (memSize == 2'b10);
    assign is_dbl   = (memSize == 2'b11);
    assign mis      = (is_half & aluResultMem[0])
                    | (is_word & (aluResultMem[1:0] != 2'b00))
                    | (is_dbl  & (aluResultMem[2:0] != 3'b000));
    assign tcnt_inc = tcnt_q + 1'b1;
    assign addr_w   = {aluResultMem[31:2], 2'b00};

    // Little-endian lane select from the first beat.
    assign byte_sel = lo_q[{aluResultMem[1:0], 3'b000} +: 8];
    assign half_sel = lo_q[{aluResultMem[1], 4'b0000} +: 16];

    always_comb begin
        load_fmt = lo_q;
        if (is_byte)      load_fmt = {{24{memSigned & byte_sel[7]}}, byte_sel};
        else if (is_half) load_fmt = {{16{memSigned & half_sel[15]}}, half_sel};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        tcnt_d  = tcnt_q;
        tflag_d = tflag_q;
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (op && !mis) state_d = S_BEAT0;
            end
            S_BEAT0, S_BEAT1: begin
                if (dmem.dmem_ready) begin
                    if (state_q == S_BEAT0) lo_d = dmem.dmem_rdata;
                    else                    hi_d = dmem.dmem_rdata;
                    state_d = (state_q == S_BEAT0 && is_dbl) ? S_BEAT1 : S_DONE;
                    tcnt_d  = '0;
                end else if (TMO_EN && tcnt_inc == TMO) begin
                    // This was the TIMEOUT-th cycle without ready: abort.
                    tflag_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            default: begin
                tflag_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            tcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_d;
        end
    end

    // Output decode. Bus outputs are zero whenever no beat is requested, and
    // everything is forced to zero while reset is asserted so the request
    // drops the moment rst_n falls.
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        dmem.dmem_be    = '0;
        memData         = '0;
        fp_busWMem      = '0;
        memStall        = 1'b0;
        memExc          = 1'b0;
        case (state_q)
            S_IDLE: begin
                memStall = op & ~mis;
                memExc   = op & mis;
            end
            S_BEAT0, S_BEAT1: begin
                memStall        = 1'b1;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = memWrite;
                dmem.dmem_addr  = (state_q == S_BEAT1) ? addr_w + 32'd4 : addr_w;
                dmem.dmem_be    = 4'b1111;
                case (memSize)
                    2'b00: dmem.dmem_wdata = {4{storeData[7:0]}};
                    2'b01: dmem.dmem_wdata = {2{storeData[15:0]}};
                    2'b10: dmem.dmem_wdata = storeData;
                    default: dmem.dmem_wdata = (state_q == S_BEAT1) ?
                                               fp_storeData[63:32] : fp_storeData[31:0];
                endcase
                if (memWrite && is_byte) dmem.dmem_be = 4'b0001 << aluResultMem[1:0];
                if (memWrite && is_half) dmem.dmem_be = aluResultMem[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                memExc = tflag_q;
                if (memRead && !tflag_q) begin
                    memData    = load_fmt;
                    fp_busWMem = is_dbl ? {hi_q, lo_q} : {32'b0, load_fmt};
                end
            end
        endcase
        memWrEn   = ~memStall;
        dbg_state = state_q;
        if (!rst_n) begin
            dmem.dmem_req   = 1'b0;
            dmem.dmem_we    = 1'b0;
            dmem.dmem_addr  = '0;
            dmem.dmem_wdata = '0;
            dmem.dmem_be    = '0;
            memData         = '0;
            fp_busWMem      = '0;
            memStall        = 1'b0;
            memWrEn         = 1'b0;
            memExc          = 1'b0;
            dbg_state       = 2'd0;
        end
    end

endmodule
